sdrc_wb_cmd_monitor: RTL and testbench

SDRC_WB_CMD_MONITOR -- requirements
Module: sdrc_wb_cmd_monitor

---
 rtl/sdrc_wb_pkg.sv | 82 ++++++++
 rtl/sdrc_wb_cmd_monitor_if.sv | 28 ++
 rtl/sdrc_wb_bank_tracker.sv | 55 +++++
 rtl/sdrc_wb_cmd_monitor.sv | 182 ++++++++++++++++++
 tb/tb_sdrc_wb_cmd_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdrc_wb_pkg.sv
// Purpose : shared types and constants for the SDRAM command-bus monitor.
// Latency : n/a (types, constants and a combinational decode helper only).
// Backpressure: n/a.
// Contents: cmd_e (decoded SDRAM command), err_e (protocol error), bank_state_e,
//           default timing constants, decode_cmd() and lowest_bank() helpers.
package sdrc_wb_pkg;

    typedef enum logic [3:0] {
        CMD_NONE    = 4'd0,
        CMD_DESEL   = 4'd1,
        CMD_NOP     = 4'd2,
        CMD_ACT     = 4'd3,
        CMD_READ    = 4'd4,
        CMD_WRITE   = 4'd5,
        CMD_PRE     = 4'd6,
        CMD_PRE_ALL = 4'd7,
        CMD_REF     = 4'd8,
        CMD_MRS     = 4'd9,
        CMD_BST     = 4'd10
    } cmd_e;

    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_PRE_INIT = 4'd1,
        ERR_ACT_OPEN = 4'd2,
        ERR_RW_IDLE  = 4'd3,
        ERR_REF_OPEN = 4'd4,
        ERR_TRCD     = 4'd5,
        ERR_TRP      = 4'd6,
        ERR_TRAS     = 4'd7,
        ERR_REFI     = 4'd8
    } err_e;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_e;

    localparam int         DEF_TRCD  = 3;
    localparam int         DEF_TRP   = 3;
    localparam int         DEF_TRAS  = 6;
    localparam int         DEF_TREFI = 1560;
    localparam int         NUM_BANKS = 4;
    localparam logic [7:0] AGE_MAX   = 8'hFF;

    // Decode the command pins; a deasserted clock enable reads as NOP.
    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n,
                                        input logic ras_n, input logic cas_n,
                                        input logic we_n, input logic a10);
        cmd_e c;
        c = CMD_NOP;
        if (cke) begin
            if (cs_n) begin
                c = CMD_DESEL;
            end else begin
                case ({ras_n, cas_n, we_n})
                    3'b111:  c = CMD_NOP;
                    3'b011:  c = CMD_ACT;
                    3'b101:  c = CMD_READ;
                    3'b100:  c = CMD_WRITE;
                    3'b010:  c = a10 ? CMD_PRE_ALL : CMD_PRE;
                    3'b001:  c = CMD_REF;
                    3'b000:  c = CMD_MRS;
                    3'b110:  c = CMD_BST;
                    default: c = CMD_NOP;
                endcase
            end
        end
        return c;
    endfunction

    // Index of the lowest set bit (0 when none set).
    function automatic logic [1:0] lowest_bank(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sdrc_wb_cmd_monitor_if.sv
// Purpose : SDRAM command-pin bundle observed by the monitor.
// Latency : n/a (wires only).
// Backpressure: none; the monitor is a passive observer.
// Ports   : cke/cs_n/ras_n/cas_n/we_n command pins, ba, addr (bit 10 = auto/all),
//           dqm byte masks, init_done. master = controller side, slave = monitor side.
interface sdrc_wb_cmd_monitor_if #(
    parameter int SDR_BW = 2
);
    logic              sdr_cke;
    logic              sdr_cs_n;
    logic              sdr_ras_n;
    logic              sdr_cas_n;
    logic              sdr_we_n;
    logic [1:0]        sdr_ba;
    logic [12:0]       sdr_addr;
    logic [SDR_BW-1:0] sdr_dqm;
    logic              sdr_init_done;

    modport master (
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        output sdr_ba, sdr_addr, sdr_dqm, sdr_init_done
    );

    modport slave (
        input sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
        input sdr_ba, sdr_addr, sdr_dqm, sdr_init_done
    );
endinterface

// File: rtl/sdrc_wb_bank_tracker.sv
// Purpose : one SDRAM bank: IDLE/ACTIVE state plus cycles-since-ACT and cycles-since-PRE ages.
// Latency : state and ages update on the edge that samples the command; violation flags are
//           combinational from registered ages. Backpressure: none.
// Ports   : clk, rst (sync, active-high), act/pre strobes for this bank;
//           open, trcd_viol, trp_viol, tras_viol.
module sdrc_wb_bank_tracker
    import sdrc_wb_pkg::*;
#(
    parameter int TRCD = DEF_TRCD,
    parameter int TRP  = DEF_TRP,
    parameter int TRAS = DEF_TRAS
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    input  logic pre,
    output logic open,
    output logic trcd_viol,
    output logic trp_viol,
    output logic tras_viol
);

    bank_state_e state;
    // Age = number of edges since the command was sampled, so a command sampled N
    // cycles after ACT sees act_age == N. Resets to AGE_MAX so nothing trips after reset.
    logic [7:0]  act_age;
    logic [7:0]  pre_age;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BANK_IDLE;
            act_age <= AGE_MAX;
            pre_age <= AGE_MAX;
        end else begin
            case (state)
                BANK_IDLE:   if (act) state <= BANK_ACTIVE;
                BANK_ACTIVE: if (pre) state <= BANK_IDLE;
                default:     state <= BANK_IDLE;
            endcase

            if (act)                     act_age <= 8'd1;
            else if (act_age != AGE_MAX) act_age <= act_age + 8'd1;

            if (pre)                     pre_age <= 8'd1;
            else if (pre_age != AGE_MAX) pre_age <= pre_age + 8'd1;
        end
    end

    assign open      = (state == BANK_ACTIVE);
    assign trcd_viol = (int'(act_age) < TRCD);
    assign trp_viol  = (int'(pre_age) < TRP);
    // Precharging an idle bank is legal, so tRAS only matters while open.
    assign tras_viol = open && (int'(act_age) < TRAS);

endmodule

// File: rtl/sdrc_wb_cmd_monitor.sv
// Purpose : passive SDRAM command-bus monitor: decodes commands, tracks 4 banks, flags
//           protocol/timing errors and counts ACT/RD/WR/REF. Optional refresh-interval
//           check under `SDRC_WB_REFRESH_CHK_EN. Latency: all outputs 1 cycle after sampling edge.
// Backpressure: none; observes only.
// Ports   : sdram_clk, sdram_reset (sync, active-high), sdr (pin bundle, slave);
//           cmd_valid/code/ba/addr/dqm, err_valid/code/ba, bank_open, act/rd/wr/ref_cnt.
module sdrc_wb_cmd_monitor
    import sdrc_wb_pkg::*;
#(
    parameter int SDR_DW = 32,   // DQ width, kept for drop-in parameter compatibility
    parameter int SDR_BW = 2,
    parameter int TRCD   = DEF_TRCD,
    parameter int TRP    = DEF_TRP,
    parameter int TRAS   = DEF_TRAS,
    parameter int TREFI  = DEF_TREFI
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    sdrc_wb_cmd_monitor_if.slave sdr,
    output logic              cmd_valid,
    output logic [3:0]        cmd_code,
    output logic [1:0]        cmd_ba,
    output logic [12:0]       cmd_addr,
    output logic [SDR_BW-1:0] cmd_dqm,
    output logic              err_valid,
    output logic [3:0]        err_code,
    output logic [1:0]        err_ba,
    output logic [3:0]        bank_open,
    output logic [15:0]       act_cnt,
    output logic [15:0]       rd_cnt,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       ref_cnt
);

    cmd_e       cmd;
    logic       is_act, is_rd, is_wr, is_rw, is_pre, is_pre_all, is_ref, is_bst;
    logic [3:0] ba_dec, act_b, pre_b;
    logic [3:0] open_v, trcd_v, trp_v, tras_v;
    logic       pre_init, act_open, rw_idle, ref_open, trcd_err, trp_err, tras_one, tras_all;
    logic       cmd_err, refi_hit;
    err_e       err_sel;
    logic [1:0] err_ba_sel;

    always_comb begin
        cmd = decode_cmd(sdr.sdr_cke, sdr.sdr_cs_n, sdr.sdr_ras_n, sdr.sdr_cas_n,
                         sdr.sdr_we_n, sdr.sdr_addr[10]);
    end

    assign is_act     = (cmd == CMD_ACT);
    assign is_rd      = (cmd == CMD_READ);
    assign is_wr      = (cmd == CMD_WRITE);
    assign is_rw      = is_rd || is_wr;
    assign is_pre     = (cmd == CMD_PRE);
    assign is_pre_all = (cmd == CMD_PRE_ALL);
    assign is_ref     = (cmd == CMD_REF);
    assign is_bst     = (cmd == CMD_BST);

    assign ba_dec = 4'b0001 << sdr.sdr_ba;
    assign act_b  = is_act ? ba_dec : 4'b0000;
    // Bank closes on PRE, PRE_ALL, or a read/write carrying auto-precharge (addr[10]).
    assign pre_b  = is_pre_all ? 4'b1111 :
                    (is_pre || (is_rw && sdr.sdr_addr[10])) ? ba_dec : 4'b0000;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sdrc_wb_bank_tracker #(
            .TRCD (TRCD),
            .TRP  (TRP),
            .TRAS (TRAS)
        ) u_bank (
            .clk       (sdram_clk),
            .rst       (sdram_reset),
            .act       (act_b[b]),
            .pre       (pre_b[b]),
            .open      (open_v[b]),
            .trcd_viol (trcd_v[b]),
            .trp_viol  (trp_v[b]),
            .tras_viol (tras_v[b])
        );
    end

    assign bank_open = open_v;

    assign pre_init = !sdr.sdr_init_done && (is_act || is_rw || is_bst);
    assign act_open = is_act && open_v[sdr.sdr_ba];
    assign rw_idle  = is_rw && !open_v[sdr.sdr_ba];
    assign ref_open = is_ref && (|open_v);
    assign trcd_err = is_rw && trcd_v[sdr.sdr_ba];
    assign trp_err  = is_act && trp_v[sdr.sdr_ba];
    assign tras_one = is_pre && tras_v[sdr.sdr_ba];
    assign tras_all = is_pre_all && (|tras_v);
    assign cmd_err  = pre_init || act_open || rw_idle || ref_open ||
                      trcd_err || trp_err || tras_one || tras_all;

`ifdef SDRC_WB_REFRESH_CHK_EN
    logic [15:0] refi_cnt;
    logic        refi_armed;

    // Fires once the count would pass TREFI; if a command error wins the cycle the
    // report stays pending (still armed) and comes out on the next clean cycle.
    assign refi_hit = sdr.sdr_init_done && refi_armed && !is_ref && (int'(refi_cnt) >= TREFI);

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            refi_cnt   <= 16'd0;
            refi_armed <= 1'b1;
        end else if (is_ref) begin
            refi_cnt   <= 16'd0;
            refi_armed <= 1'b1;
        end else begin
            if (sdr.sdr_init_done && refi_cnt != 16'hFFFF) refi_cnt <= refi_cnt + 16'd1;
            if (refi_hit && !cmd_err) refi_armed <= 1'b0;
        end
    end
`else
    assign refi_hit = 1'b0;
`endif

    // Single reported error, highest priority first.
    always_comb begin
        err_sel    = ERR_NONE;
        err_ba_sel = 2'd0;
        if (pre_init) begin
            err_sel    = ERR_PRE_INIT;
            err_ba_sel = sdr.sdr_ba;
        end else if (act_open) begin
            err_sel    = ERR_ACT_OPEN;
            err_ba_sel = sdr.sdr_ba;
        end else if (rw_idle) begin
            err_sel    = ERR_RW_IDLE;
            err_ba_sel = sdr.sdr_ba;
        end else if (ref_open) begin
            err_sel    = ERR_REF_OPEN;
            err_ba_sel = lowest_bank(open_v);
        end else if (trcd_err) begin
            err_sel    = ERR_TRCD;
            err_ba_sel = sdr.sdr_ba;
        end else if (trp_err) begin
            err_sel    = ERR_TRP;
            err_ba_sel = sdr.sdr_ba;
        end else if (tras_one) begin
            err_sel    = ERR_TRAS;
            err_ba_sel = sdr.sdr_ba;
        end else if (tras_all) begin
            err_sel    = ERR_TRAS;
            err_ba_sel = lowest_bank(tras_v);
        end else if (refi_hit) begin
            err_sel    = ERR_REFI;
            err_ba_sel = 2'd0;
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_NONE;
            cmd_ba    <= 2'd0;
            cmd_addr  <= 13'd0;
            cmd_dqm   <= '0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            err_ba    <= 2'd0;
            act_cnt   <= 16'd0;
            rd_cnt    <= 16'd0;
            wr_cnt    <= 16'd0;
            ref_cnt   <= 16'd0;
        end else begin
            cmd_valid <= (cmd != CMD_NOP) && (cmd != CMD_DESEL);
            cmd_code  <= cmd;
            cmd_ba    <= sdr.sdr_ba;
            cmd_addr  <= sdr.sdr_addr;
            cmd_dqm   <= sdr.sdr_dqm;
            err_valid <= (err_sel != ERR_NONE);
            err_code  <= err_sel;
            err_ba    <= err_ba_sel;
            if (is_act && act_cnt != 16'hFFFF) act_cnt <= act_cnt + 16'd1;
            if (is_rd  && rd_cnt  != 16'hFFFF) rd_cnt  <= rd_cnt  + 16'd1;
            if (is_wr  && wr_cnt  != 16'hFFFF) wr_cnt  <= wr_cnt  + 16'd1;
            if (is_ref && ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sdrc_wb_cmd_monitor.sv
// Purpose : self-checking bench for sdrc_wb_cmd_monitor; a cycle model pushes the expected
//           output record per driven command and the record is popped one edge later.
// Latency : expects every output 1 cycle after the sampling edge. Backpressure: n/a.
module tb_sdrc_wb_cmd_monitor;
    import sdrc_wb_pkg::*;

    localparam int TB_TRCD  = 3;
    localparam int TB_TRP   = 3;
    localparam int TB_TRAS  = 6;
    localparam int TB_TREFI = 20;

    logic        sdram_clk = 1'b0;
    logic        sdram_reset;
    logic        cmd_valid, err_valid;
    logic [3:0]  cmd_code, err_code, bank_open;
    logic [1:0]  cmd_ba, cmd_dqm, err_ba;
    logic [12:0] cmd_addr;
    logic [15:0] act_cnt, rd_cnt, wr_cnt, ref_cnt;

    always #5 sdram_clk = ~sdram_clk;

    sdrc_wb_cmd_monitor_if #(.SDR_BW(2)) sdr ();

    sdrc_wb_cmd_monitor #(
        .SDR_DW (32), .SDR_BW (2), .TRCD (TB_TRCD), .TRP (TB_TRP),
        .TRAS (TB_TRAS), .TREFI (TB_TREFI)
    ) dut (
        .sdram_clk (sdram_clk), .sdram_reset (sdram_reset), .sdr (sdr),
        .cmd_valid (cmd_valid), .cmd_code (cmd_code), .cmd_ba (cmd_ba),
        .cmd_addr (cmd_addr), .cmd_dqm (cmd_dqm), .err_valid (err_valid),
        .err_code (err_code), .err_ba (err_ba), .bank_open (bank_open),
        .act_cnt (act_cnt), .rd_cnt (rd_cnt), .wr_cnt (wr_cnt), .ref_cnt (ref_cnt)
    );

    typedef struct {
        logic        cmd_valid;
        logic [3:0]  cmd_code;
        logic [1:0]  cmd_ba;
        logic [12:0] cmd_addr;
        logic [1:0]  cmd_dqm;
        logic        err_valid;
        logic [3:0]  err_code;
        logic [1:0]  err_ba;
        logic [3:0]  bank_open;
        logic [15:0] act_cnt, rd_cnt, wr_cnt, ref_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;
    bit   cur_init = 1'b0;

    // Reference model state
    bit   m_open[4];
    int   m_act_age[4];
    int   m_pre_age[4];
    int   m_act_cnt, m_rd_cnt, m_wr_cnt, m_ref_cnt;
    int   m_refi_cnt;
    bit   m_refi_armed;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", tag, step_no, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 1'b0; m_act_age[i] = 255; m_pre_age[i] = 255;
        end
        m_act_cnt = 0; m_rd_cnt = 0; m_wr_cnt = 0; m_ref_cnt = 0;
        m_refi_cnt = 0; m_refi_armed = 1'b1;
    endtask

    function automatic logic [1:0] first_of(input bit v[4]);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic model_push(input bit rst, input cmd_e c, input logic [1:0] ba,
                              input logic [12:0] a, input logic [1:0] dqm, input bit init, input bit cke);
        exp_t e;
        cmd_e eff;
        bit   rw, any_open, refi_due;
        bit   tv[4];
        bit   ov[4];
        e = '{default: '0};
        if (rst) begin
            model_reset();
        end else begin
            eff = cke ? c : CMD_NOP;
            rw  = (eff == CMD_READ) || (eff == CMD_WRITE);
            any_open = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ov[i] = m_open[i];
                tv[i] = m_open[i] && (m_act_age[i] < TB_TRAS);
                any_open |= m_open[i];
            end
            e.cmd_valid = (eff != CMD_NOP) && (eff != CMD_DESEL);
            e.cmd_code = eff; e.cmd_ba = ba; e.cmd_addr = a; e.cmd_dqm = dqm;
            e.err_code = ERR_NONE; e.err_ba = 2'd0;
            if (!init && (eff == CMD_ACT || rw || eff == CMD_BST)) begin
                e.err_code = ERR_PRE_INIT; e.err_ba = ba;
            end else if (eff == CMD_ACT && m_open[ba]) begin
                e.err_code = ERR_ACT_OPEN; e.err_ba = ba;
            end else if (rw && !m_open[ba]) begin
                e.err_code = ERR_RW_IDLE; e.err_ba = ba;
            end else if (eff == CMD_REF && any_open) begin
                e.err_code = ERR_REF_OPEN; e.err_ba = first_of(ov);
            end else if (rw && m_act_age[ba] < TB_TRCD) begin
                e.err_code = ERR_TRCD; e.err_ba = ba;
            end else if (eff == CMD_ACT && m_pre_age[ba] < TB_TRP) begin
                e.err_code = ERR_TRP; e.err_ba = ba;
            end else if (eff == CMD_PRE && tv[ba]) begin
                e.err_code = ERR_TRAS; e.err_ba = ba;
            end else if (eff == CMD_PRE_ALL && (tv[0] || tv[1] || tv[2] || tv[3])) begin
                e.err_code = ERR_TRAS; e.err_ba = first_of(tv);
            end
            refi_due = 1'b0;
`ifdef SDRC_WB_REFRESH_CHK_EN
            refi_due = init && m_refi_armed && (eff != CMD_REF) && (m_refi_cnt >= TB_TREFI);
            if (e.err_code == ERR_NONE && refi_due) begin
                e.err_code = ERR_REFI; m_refi_armed = 1'b0;
            end
            if (eff == CMD_REF) begin
                m_refi_cnt = 0; m_refi_armed = 1'b1;
            end else if (init && m_refi_cnt < 65535) begin
                m_refi_cnt++;
            end
`endif
            e.err_valid = (e.err_code != ERR_NONE) || refi_due && 1'b0;
            for (int i = 0; i < 4; i++) begin
                bit ah, ph;
                ah = (eff == CMD_ACT) && (ba == 2'(i));
                ph = (eff == CMD_PRE_ALL) || (((eff == CMD_PRE) || (rw && a[10])) && (ba == 2'(i)));
                if (ah) m_open[i] = 1'b1;
                else if (ph) m_open[i] = 1'b0;
                m_act_age[i] = ah ? 1 : (m_act_age[i] < 255 ? m_act_age[i] + 1 : 255);
                m_pre_age[i] = ph ? 1 : (m_pre_age[i] < 255 ? m_pre_age[i] + 1 : 255);
            end
            if (eff == CMD_ACT   && m_act_cnt < 65535) m_act_cnt++;
            if (eff == CMD_READ  && m_rd_cnt  < 65535) m_rd_cnt++;
            if (eff == CMD_WRITE && m_wr_cnt  < 65535) m_wr_cnt++;
            if (eff == CMD_REF   && m_ref_cnt < 65535) m_ref_cnt++;
        end
        e.bank_open = {m_open[3], m_open[2], m_open[1], m_open[0]};
        e.act_cnt = 16'(m_act_cnt); e.rd_cnt = 16'(m_rd_cnt);
        e.wr_cnt  = 16'(m_wr_cnt);  e.ref_cnt = 16'(m_ref_cnt);
        exp_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check_val("cmd_valid", 32'(cmd_valid), 32'(e.cmd_valid));
        check_val("cmd_code",  32'(cmd_code),  32'(e.cmd_code));
        if (e.cmd_valid) begin
            check_val("cmd_ba",   32'(cmd_ba),   32'(e.cmd_ba));
            check_val("cmd_addr", 32'(cmd_addr), 32'(e.cmd_addr));
            check_val("cmd_dqm",  32'(cmd_dqm),  32'(e.cmd_dqm));
        end
        check_val("err_valid", 32'(err_valid), 32'(e.err_valid));
        check_val("err_code",  32'(err_code),  32'(e.err_code));
        check_val("err_ba",    32'(err_ba),    32'(e.err_ba));
        check_val("bank_open", 32'(bank_open), 32'(e.bank_open));
        check_val("act_cnt",   32'(act_cnt),   32'(e.act_cnt));
        check_val("rd_cnt",    32'(rd_cnt),    32'(e.rd_cnt));
        check_val("wr_cnt",    32'(wr_cnt),    32'(e.wr_cnt));
        check_val("ref_cnt",   32'(ref_cnt),   32'(e.ref_cnt));
    endtask

    // Drive one command for one cycle, predict, then compare the registered result.
    task automatic step(input bit rst, input cmd_e c, input logic [1:0] ba,
                        input logic [12:0] addr, input bit init, input bit cke);
        logic [3:0]  pins;
        logic [12:0] a;
        logic [1:0]  dqm;
        a   = addr;
        dqm = 2'($urandom);
        if (c == CMD_PRE)     a[10] = 1'b0;
        if (c == CMD_PRE_ALL) a[10] = 1'b1;
        case (c)
            CMD_DESEL:   pins = {1'b1, 3'($urandom)};
            CMD_ACT:     pins = 4'b0011;
            CMD_READ:    pins = 4'b0101;
            CMD_WRITE:   pins = 4'b0100;
            CMD_PRE:     pins = 4'b0010;
            CMD_PRE_ALL: pins = 4'b0010;
            CMD_REF:     pins = 4'b0001;
            CMD_MRS:     pins = 4'b0000;
            CMD_BST:     pins = 4'b0110;
            default:     pins = 4'b0111;
        endcase
        sdram_reset = rst;
        sdr.sdr_cke = cke;
        {sdr.sdr_cs_n, sdr.sdr_ras_n, sdr.sdr_cas_n, sdr.sdr_we_n} = pins;
        sdr.sdr_ba = ba;
        sdr.sdr_addr = a;
        sdr.sdr_dqm = dqm;
        sdr.sdr_init_done = init;
        model_push(rst, c, ba, a, dqm, init, cke);
        @(posedge sdram_clk);
        #1;
        step_no++;
        compare_out();
    endtask

    task automatic op(input cmd_e c, input logic [1:0] ba, input logic [12:0] addr);
        step(1'b0, c, ba, addr, cur_init, 1'b1);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) op(CMD_NOP, 2'($urandom), 13'($urandom));
    endtask

    task automatic count_refi(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            op(CMD_NOP, 2'd0, 13'd0);
            if (err_valid && err_code == ERR_REFI) seen++;
        end
    endtask

    initial begin
        int   seen;
        int   exp_refi;
        cmd_e pool[10];
        pool = '{CMD_DESEL, CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE,
                 CMD_PRE, CMD_PRE_ALL, CMD_REF, CMD_MRS, CMD_BST};
`ifdef SDRC_WB_REFRESH_CHK_EN
        exp_refi = 1;
`else
        exp_refi = 0;
`endif
        model_reset();

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b1, CMD_ACT, 2'd1, 13'h1FFF, 1'b1, 1'b1);
        check_val("reset_bank_open", 32'(bank_open), 32'd0);
        check_val("reset_cmd_code", 32'(cmd_code), 32'(CMD_NONE));
        cur_init = 1'b1;

        // ACT, 3 NOPs, READ: legal
        op(CMD_ACT, 2'd1, 13'h0123);
        nops(3);
        op(CMD_READ, 2'd1, 13'h0010);
        check_val("basic_open", 32'(bank_open), 32'h2);
        check_val("basic_act_cnt", 32'(act_cnt), 32'd1);
        check_val("basic_rd_cnt", 32'(rd_cnt), 32'd1);
        check_val("basic_no_err", 32'(err_valid), 32'd0);

        // tRCD violation
        op(CMD_ACT, 2'd0, 13'h0055);
        op(CMD_READ, 2'd0, 13'h0020);
        check_val("trcd_code", 32'(err_code), 32'(ERR_TRCD));
        check_val("trcd_ba", 32'(err_ba), 32'd0);
        nops(6);
        op(CMD_PRE, 2'd0, 13'd0);
        op(CMD_PRE, 2'd1, 13'd0);
        op(CMD_PRE, 2'd3, 13'd0);   // idle bank: legal
        check_val("pre_idle_no_err", 32'(err_valid), 32'd0);

        // PRE_INIT wins over RW_IDLE
        cur_init = 1'b0;
        op(CMD_WRITE, 2'd2, 13'h0040);
        check_val("preinit_code", 32'(err_code), 32'(ERR_PRE_INIT));
        check_val("preinit_wr_cnt", 32'(wr_cnt), 32'd1);
        cur_init = 1'b1;
        nops(3);

        // All banks open, PRE_ALL, REF
        for (int b = 0; b < 4; b++) op(CMD_ACT, 2'(b), 13'h0100 + 13'(b));
        check_val("all_open", 32'(bank_open), 32'hF);
        nops(6);
        op(CMD_PRE_ALL, 2'd0, 13'd0);
        check_val("preall_closed", 32'(bank_open), 32'h0);
        check_val("preall_no_err", 32'(err_valid), 32'd0);
        op(CMD_REF, 2'd0, 13'd0);
        check_val("ref_no_err", 32'(err_valid), 32'd0);
        nops(2);
        op(CMD_ACT, 2'd2, 13'h0777);
        nops(2);
        op(CMD_REF, 2'd0, 13'd0);
        check_val("ref_open_code", 32'(err_code), 32'(ERR_REF_OPEN));
        check_val("ref_open_ba", 32'(err_ba), 32'd2);

        // ACT_OPEN, RW_IDLE, TRAS, TRP
        nops(5);
        op(CMD_ACT, 2'd2, 13'h0001);
        check_val("act_open_code", 32'(err_code), 32'(ERR_ACT_OPEN));
        op(CMD_READ, 2'd1, 13'h0008);
        check_val("rw_idle_code", 32'(err_code), 32'(ERR_RW_IDLE));
        op(CMD_ACT, 2'd0, 13'h0002);
        op(CMD_PRE, 2'd0, 13'd0);
        check_val("tras_code", 32'(err_code), 32'(ERR_TRAS));
        op(CMD_ACT, 2'd0, 13'h0003);
        check_val("trp_code", 32'(err_code), 32'(ERR_TRP));

        // PRE_ALL reports lowest violating bank, not lowest open bank
        nops(6);
        op(CMD_ACT, 2'd1, 13'h0004);
        op(CMD_ACT, 2'd3, 13'h0005);
        op(CMD_PRE_ALL, 2'd0, 13'd0);
        check_val("preall_tras_code", 32'(err_code), 32'(ERR_TRAS));
        check_val("preall_tras_ba", 32'(err_ba), 32'd1);

        // Auto-precharge write closes the bank
        nops(3);
        op(CMD_ACT, 2'd2, 13'h0006);
        nops(3);
        op(CMD_WRITE, 2'd2, 13'h0400);
        check_val("autopre_closed", 32'(bank_open), 32'h0);

        // Misc commands, clock enable low
        op(CMD_MRS, 2'd0, 13'h0033);
        op(CMD_DESEL, 2'd1, 13'h0000);
        step(1'b0, CMD_ACT, 2'd3, 13'h0009, 1'b1, 1'b0);
        check_val("cke_low_no_cmd", 32'(cmd_valid), 32'd0);
        op(CMD_BST, 2'd0, 13'd0);

        // Reset mid-operation discards the command on that edge
        op(CMD_ACT, 2'd1, 13'h0011);
        step(1'b1, CMD_ACT, 2'd3, 13'h0012, 1'b1, 1'b1);
        check_val("midrst_open", 32'(bank_open), 32'h0);
        check_val("midrst_act_cnt", 32'(act_cnt), 32'd0);

        // Refresh interval: one pulse per REF window in the checking build
        op(CMD_REF, 2'd0, 13'd0);
        count_refi(25, seen);
        check_val("refi_first_window", 32'(seen), 32'(exp_refi));
        op(CMD_REF, 2'd0, 13'd0);
        count_refi(25, seen);
        check_val("refi_rearmed_window", 32'(seen), 32'(exp_refi));

        // Random command stream against the model
        for (int i = 0; i < 400; i++) begin
            int   k;
            cmd_e c;
            k = $urandom_range(0, 13);
            c = (k > 9) ? CMD_NOP : pool[k];
            step(1'b0, c, 2'($urandom), 13'($urandom),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
